// File: rtl/spio_flit_arb_pkg.sv
// Shared constants and state encoding for the SpiNNaker link flit arbiter.
package spio_flit_arb_pkg;

    localparam logic [6:0]  EOP_2OF7  = 7'h60;
    localparam int unsigned MAX_PORTS = 8;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DRAIN,
        INJECT
    } arb_state_t;

endpackage

// File: rtl/spio_flit_arb_rr_select.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module spio_flit_arb_rr_select
    import spio_flit_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned PTR_W     = 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_sel,
    output logic                 o_any
);

    logic        w_found;
    int unsigned w_idx;

    always_comb begin
        o_sel   = '0;
        o_any   = |i_req;
        w_found = 1'b0;
        w_idx   = 0;
        // Walk offsets from the pointer; the first hit wins.
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_idx = 32'(i_ptr) + k;
            if (w_idx >= NUM_PORTS) begin
                w_idx = w_idx - NUM_PORTS;
            end
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!w_found && i_req[i] && (i == w_idx)) begin
                    o_sel[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spio_spinnaker_link_flit_arbiter.sv
// Packet-granular round-robin merge of 2-of-7 flit streams into one deserializer.
// Optional mid-packet stall watchdog enabled by `define SPIO_FLIT_ARB_WATCHDOG_EN.
module spio_spinnaker_link_flit_arbiter
    import spio_flit_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned MAX_FLITS = 19,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic                   CLK_IN,
    input  logic                   RESET_IN,
    input  logic [7*NUM_PORTS-1:0] in_data_2of7,
    input  logic [NUM_PORTS-1:0]   in_vld,
    output logic [NUM_PORTS-1:0]   in_rdy,
    output logic [6:0]             out_data_2of7,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [NUM_PORTS-1:0]   grant,
    output logic                   err_len,
    output logic                   err_timeout
);

    localparam int unsigned PTR_W = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W = $clog2(MAX_FLITS + 1);

    if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS || MAX_FLITS < 1 || TIMEOUT < 1) begin : g_cfg_check
        $error("spio_spinnaker_link_flit_arbiter: illegal parameter set");
    end

    arb_state_t           r_state, w_state_nxt;
    logic [NUM_PORTS-1:0] r_grant;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]     r_flit_cnt;
    logic                 r_out_vld;
    logic [6:0]           r_out_data;
    logic                 r_err_len;

    logic [NUM_PORTS-1:0] w_sel;
    logic                 w_any;
    logic [PTR_W-1:0]     w_gidx;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [6:0]           w_g_data;
    logic                 w_g_vld;
    logic                 w_out_free;
    logic [NUM_PORTS-1:0] w_in_rdy;
    logic                 w_load;
    logic [6:0]           w_load_data;
    logic                 w_err_len;
    logic                 w_release;
    logic                 w_cnt_inc;

`ifdef SPIO_FLIT_ARB_WATCHDOG_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_err_timeout;
    logic              w_err_timeout;
    logic              w_timed_out;
    assign w_timed_out = (r_idle_cnt == IDLE_W'(TIMEOUT));
`endif

    spio_flit_arb_rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_select (
        .i_req (in_vld),
        .i_ptr (r_rr_ptr),
        .o_sel (w_sel),
        .o_any (w_any)
    );

    always_comb begin
        w_gidx   = '0;
        w_g_data = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (r_grant[i]) begin
                w_gidx   = PTR_W'(i);
                w_g_data = in_data_2of7[7*i +: 7];
            end
        end
    end

    assign w_g_vld    = |(in_vld & r_grant);
    assign w_out_free = !r_out_vld || out_rdy;
    assign w_ptr_nxt  = (32'(w_gidx) == NUM_PORTS - 1) ? '0 : w_gidx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_in_rdy    = '0;
        w_load      = 1'b0;
        w_load_data = r_out_data;
        w_err_len   = 1'b0;
        w_release   = 1'b0;
        w_cnt_inc   = 1'b0;
`ifdef SPIO_FLIT_ARB_WATCHDOG_EN
        w_err_timeout = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = FWD;
                end
            end
            FWD: begin
`ifdef SPIO_FLIT_ARB_WATCHDOG_EN
                if (w_timed_out) begin
                    w_state_nxt = INJECT;
                end else
`endif
                if (w_g_vld && w_out_free) begin
                    w_in_rdy  = r_grant;
                    w_load    = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (w_g_data == EOP_2OF7) begin
                        w_load_data = EOP_2OF7;
                        w_release   = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (r_flit_cnt == CNT_W'(MAX_FLITS - 1)) begin
                        // Last permitted slot: terminate the packet here.
                        w_load_data = EOP_2OF7;
                        w_err_len   = 1'b1;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_load_data = w_g_data;
                    end
                end
            end
            DRAIN: begin
                if (w_g_vld) begin
                    w_in_rdy = r_grant;
                    if (w_g_data == EOP_2OF7) begin
                        w_release   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
`ifdef SPIO_FLIT_ARB_WATCHDOG_EN
            INJECT: begin
                if (w_out_free) begin
                    w_load        = 1'b1;
                    w_load_data   = EOP_2OF7;
                    w_err_timeout = 1'b1;
                    w_state_nxt   = DRAIN;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_flit_cnt <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_err_len  <= 1'b0;
        end else begin
            r_err_len <= w_err_len;
            if (w_load) begin
                r_out_vld  <= 1'b1;
                r_out_data <= w_load_data;
            end else if (out_rdy) begin
                r_out_vld <= 1'b0;
            end
            if (r_state == IDLE && w_any) begin
                r_grant <= w_sel;
            end else if (w_release) begin
                r_grant  <= '0;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (w_release) begin
                r_flit_cnt <= '0;
            end else if (w_cnt_inc && r_flit_cnt != CNT_W'(MAX_FLITS)) begin
                r_flit_cnt <= r_flit_cnt + 1'b1;
            end
        end
    end

`ifdef SPIO_FLIT_ARB_WATCHDOG_EN
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            r_idle_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_err_timeout;
            if (r_state != FWD || w_load) begin
                r_idle_cnt <= '0;
            end else if (!w_g_vld && !w_timed_out) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end
    assign err_timeout = r_err_timeout;
`else
    assign err_timeout = 1'b0;
`endif

    assign in_rdy        = w_in_rdy;
    assign out_vld       = r_out_vld;
    assign out_data_2of7 = r_out_data;
    assign grant         = r_grant;
    assign err_len       = r_err_len;

endmodule

// File: tb/tb_spio_spinnaker_link_flit_arbiter.sv
// Directed bench for the flit arbiter: per-cycle vector table plus packet-level sequences.
module tb_spio_spinnaker_link_flit_arbiter;

    localparam int unsigned MAX_FLITS = 19;
    localparam logic [6:0]  EOP       = 7'h60;

    logic        clk;
    logic        rst;
    logic [13:0] in_data;
    logic [1:0]  in_vld;
    logic [1:0]  in_rdy;
    logic [6:0]  out_data;
    logic        out_vld;
    logic        out_rdy;
    logic [1:0]  grant;
    logic        err_len;
    logic        err_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [6:0] q_out[$];
    int         n_errl;
    int         n_errt;
    logic       grant_lost;

    spio_spinnaker_link_flit_arbiter #(
        .NUM_PORTS (2),
        .MAX_FLITS (MAX_FLITS),
        .TIMEOUT   (8)
    ) dut (
        .CLK_IN        (clk),
        .RESET_IN      (rst),
        .in_data_2of7  (in_data),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .out_data_2of7 (out_data),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .grant         (grant),
        .err_len       (err_len),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] vld;
        logic [6:0] d0;
        logic [6:0] d1;
        logic       ordy;
        logic [1:0] e_grant;
        logic [1:0] e_rdy;
        logic       e_ovld;
        logic [6:0] e_od;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one packet of ndata data flits plus EOP on a port, optionally pausing
    // gap_len cycles once gap_at flits have been accepted; record everything output.
    task automatic run_pkt(input int port, input int ndata, input int gap_at, input int gap_len);
        int k;
        int gap;
        bit done;
        k = 0; gap = 0; done = 0;
        q_out.delete(); n_errl = 0; n_errt = 0; grant_lost = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (k > ndata && grant == 2'b00 && !out_vld) begin
                done = 1;
                break;
            end
            in_vld = 2'b00;
            if (k == gap_at && gap < gap_len) begin
                gap++;
                if (grant != 2'(1 << port)) grant_lost = 1'b1;
            end else if (k <= ndata) begin
                in_vld[port] = 1'b1;
                in_data[7*port +: 7] = (k == ndata) ? EOP : 7'(k + 1);
            end
            #1;
            if (out_vld && out_rdy) q_out.push_back(out_data);
            n_errl += int'(err_len);
            n_errt += int'(err_timeout);
            if (in_vld[port] && in_rdy[port]) k++;
        end
        in_vld = 2'b00;
        check("pkt_complete", 32'(done), 32'd1);
    endtask

    task automatic check_pkt(input string nm, input int ndata, input int exp_errl, input int exp_errt);
        int nd;
        nd = (ndata > int'(MAX_FLITS) - 1) ? int'(MAX_FLITS) - 1 : ndata;
        check({nm, "_count"}, 32'(q_out.size()), 32'(nd + 1));
        for (int i = 0; i <= nd && i < q_out.size(); i++) begin
            check({nm, "_flit"}, 32'(q_out[i]), (i == nd) ? 32'(EOP) : 32'(i + 1));
        end
        check({nm, "_err_len"}, 32'(n_errl), 32'(exp_errl));
        check({nm, "_err_timeout"}, 32'(n_errt), 32'(exp_errt));
        check({nm, "_grant_held"}, 32'(grant_lost), 32'd0);
    endtask

    initial begin
        vec_t tbl[17];
        tbl[0]  = '{2'b01, 7'h03, 7'h00, 1'b1, 2'b00, 2'b00, 1'b0, 7'h00};
        tbl[1]  = '{2'b01, 7'h03, 7'h00, 1'b1, 2'b01, 2'b01, 1'b0, 7'h00};
        tbl[2]  = '{2'b01, 7'h05, 7'h00, 1'b1, 2'b01, 2'b01, 1'b1, 7'h03};
        tbl[3]  = '{2'b01, 7'h60, 7'h00, 1'b1, 2'b01, 2'b01, 1'b1, 7'h05};
        tbl[4]  = '{2'b11, 7'h60, 7'h09, 1'b1, 2'b00, 2'b00, 1'b1, 7'h60};
        tbl[5]  = '{2'b11, 7'h60, 7'h09, 1'b1, 2'b10, 2'b10, 1'b0, 7'h60};
        tbl[6]  = '{2'b11, 7'h60, 7'h60, 1'b1, 2'b10, 2'b10, 1'b1, 7'h09};
        tbl[7]  = '{2'b11, 7'h60, 7'h60, 1'b1, 2'b00, 2'b00, 1'b1, 7'h60};
        tbl[8]  = '{2'b11, 7'h60, 7'h60, 1'b1, 2'b01, 2'b01, 1'b0, 7'h60};
        tbl[9]  = '{2'b10, 7'h00, 7'h0B, 1'b1, 2'b00, 2'b00, 1'b1, 7'h60};
        tbl[10] = '{2'b10, 7'h00, 7'h0B, 1'b1, 2'b10, 2'b10, 1'b0, 7'h60};
        tbl[11] = '{2'b10, 7'h00, 7'h0D, 1'b0, 2'b10, 2'b00, 1'b1, 7'h0B};
        tbl[12] = '{2'b10, 7'h00, 7'h0D, 1'b0, 2'b10, 2'b00, 1'b1, 7'h0B};
        tbl[13] = '{2'b10, 7'h00, 7'h0D, 1'b1, 2'b10, 2'b10, 1'b1, 7'h0B};
        tbl[14] = '{2'b10, 7'h00, 7'h60, 1'b1, 2'b10, 2'b10, 1'b1, 7'h0D};
        tbl[15] = '{2'b00, 7'h00, 7'h00, 1'b1, 2'b00, 2'b00, 1'b1, 7'h60};
        tbl[16] = '{2'b00, 7'h00, 7'h00, 1'b1, 2'b00, 2'b00, 1'b0, 7'h60};

        rst = 1'b1; in_vld = 2'b00; in_data = '0; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_in_rdy", 32'(in_rdy), 32'd0);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_err_len", 32'(err_len), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);

        // Port 0 packet, alternating arbitration, 1-flit packet, output backpressure.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_vld  = tbl[i].vld;
            in_data = {tbl[i].d1, tbl[i].d0};
            out_rdy = tbl[i].ordy;
            #1;
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
            check($sformatf("vec%0d_in_rdy", i), 32'(in_rdy), 32'(tbl[i].e_rdy));
            check($sformatf("vec%0d_out_vld", i), 32'(out_vld), 32'(tbl[i].e_ovld));
            check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            check($sformatf("vec%0d_err_len", i), 32'(err_len), 32'd0);
        end
        in_vld = 2'b00;
        out_rdy = 1'b1;

        run_pkt(1, 24, -1, 0);
        check_pkt("trunc25", 24, 1, 0);

        run_pkt(0, 18, -1, 0);
        check_pkt("exact19", 18, 0, 0);

        run_pkt(0, 3, 3, 12);
`ifdef SPIO_FLIT_ARB_WATCHDOG_EN
        check_pkt("stall", 3, 0, 1);
`else
        check_pkt("stall", 3, 0, 0);
`endif

        // Reset mid-packet from port 1; afterwards arbitration restarts at port 0.
        @(negedge clk);
        in_vld = 2'b10; in_data[13:7] = 7'h31;
        @(negedge clk);
        @(negedge clk);
        in_data[13:7] = 7'h32;
        #1;
        check("pre_rst_grant", 32'(grant), 32'h2);
        check("pre_rst_out_vld", 32'(out_vld), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_vld = 2'b11; in_data = {7'h33, 7'h41};
        #1;
        check("post_rst_grant", 32'(grant), 32'd0);
        check("post_rst_in_rdy", 32'(in_rdy), 32'd0);
        check("post_rst_out_vld", 32'(out_vld), 32'd0);
        check("post_rst_out_data", 32'(out_data), 32'd0);
        check("post_rst_err_len", 32'(err_len), 32'd0);
        @(negedge clk);
        #1;
        check("post_rst_rr_grant", 32'(grant), 32'h1);
        in_vld = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
